// File: rtl/alu16_seq.sv
// alu16_seq: drives an external 8-bit ALU twice per command (low byte, then high byte)
// to perform 16-bit operations, chaining the carry and merging the per-byte flags.
`default_nettype none

module alu16_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  cmd,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic        busy,
   output logic        done,
   output logic [15:0] res,
   output logic [2:0]  flags,
   output logic [7:0]  alu_x,
   output logic [7:0]  alu_y,
   output logic        alu_cy,
   output logic [4:0]  alu_op,
   input  logic [2:0]  alu_flag,
   input  logic [7:0]  alu_result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LO   = 2'd1;
   localparam logic [1:0] S_HI   = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   localparam logic [2:0] CMD_ADD = 3'b000;
   localparam logic [2:0] CMD_ADC = 3'b001;
   localparam logic [2:0] CMD_SUB = 3'b010;
   localparam logic [2:0] CMD_INC = 3'b011;
   localparam logic [2:0] CMD_AND = 3'b100;
   localparam logic [2:0] CMD_OR  = 3'b101;
   localparam logic [2:0] CMD_XOR = 3'b110;
   localparam logic [2:0] CMD_SHL = 3'b111;

   logic [1:0] r_state;
   logic [2:0] r_cmd;
   logic [7:0] r_a_hi;
   logic [7:0] r_b_hi;
   logic [7:0] r_res_lo;
   logic       r_z_lo;

   // Returns {op, cy} for the low-byte ALU pass.
   function automatic logic [5:0] lo_prog(input logic [2:0] c, input logic ci);
      case (c)
         CMD_ADD: lo_prog = {5'b01000, 1'b0};
         CMD_ADC: lo_prog = {5'b01010, ci};
         CMD_SUB: lo_prog = {5'b01011, 1'b0};
         CMD_INC: lo_prog = {5'b01110, 1'b0};
         CMD_AND: lo_prog = {5'b10000, 1'b0};
         CMD_OR:  lo_prog = {5'b10001, 1'b0};
         CMD_XOR: lo_prog = {5'b10010, 1'b0};
         default: lo_prog = {5'b11011, 1'b0};
      endcase
   endfunction

   // Returns {op, cy} for the high-byte pass; SUB inverts the carry because the
   // ALU takes a borrow on its cy input but reports no-borrow as carry-out.
   function automatic logic [5:0] hi_prog(input logic [2:0] c, input logic cyl);
      case (c)
         CMD_ADD, CMD_ADC, CMD_INC: hi_prog = {5'b01010, cyl};
         CMD_SUB: hi_prog = {5'b01101, ~cyl};
         CMD_AND: hi_prog = {5'b10000, 1'b0};
         CMD_OR:  hi_prog = {5'b10001, 1'b0};
         CMD_XOR: hi_prog = {5'b10010, 1'b0};
         default: hi_prog = {5'b11010, cyl};
      endcase
   endfunction

   function automatic logic uses_b(input logic [2:0] c);
      uses_b = !(c == CMD_INC || c == CMD_SHL);
   endfunction

   function automatic logic is_logic(input logic [2:0] c);
      is_logic = (c == CMD_AND) || (c == CMD_OR) || (c == CMD_XOR);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cmd    <= 3'd0;
         r_a_hi   <= 8'd0;
         r_b_hi   <= 8'd0;
         r_res_lo <= 8'd0;
         r_z_lo   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         res      <= 16'd0;
         flags    <= 3'd0;
         alu_x    <= 8'd0;
         alu_y    <= 8'd0;
         alu_cy   <= 1'b0;
         alu_op   <= 5'd0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cmd   <= cmd;
                  r_a_hi  <= a[15:8];
                  r_b_hi  <= uses_b(cmd) ? b[15:8] : 8'd0;
                  alu_x   <= a[7:0];
                  alu_y   <= uses_b(cmd) ? b[7:0] : 8'd0;
                  {alu_op, alu_cy} <= lo_prog(cmd, cin);
                  busy    <= 1'b1;
                  r_state <= S_LO;
               end
            end
            S_LO: begin
               r_res_lo <= alu_result;
               r_z_lo   <= alu_flag[1];
               alu_x    <= r_a_hi;
               alu_y    <= r_b_hi;
               {alu_op, alu_cy} <= hi_prog(r_cmd, alu_flag[0]);
               r_state  <= S_HI;
            end
            S_HI: begin
               res     <= {alu_result, r_res_lo};
               flags   <= {alu_flag[2], r_z_lo & alu_flag[1],
                           is_logic(r_cmd) ? 1'b0 : alu_flag[0]};
               done    <= 1'b1;
               busy    <= 1'b0;
               alu_x   <= 8'd0;
               alu_y   <= 8'd0;
               alu_cy  <= 1'b0;
               alu_op  <= 5'd0;
               r_state <= S_FIN;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
- Sequential initiator that drives the 8-bit CDEC ALU (x/y/cy/op in, flag/result out) twice per command to perform 16-bit operations.
- Runs low byte first, then high byte, chaining the ALU carry between them. Merges the per-byte flags into 16-bit S/Z/Cy.
- Sits between the memory-editor/debug datapath and a dedicated ALU instance. Start/busy/done handshake.

Parameters:
- none (widths fixed: 16-bit operands, 8-bit ALU, 5-bit ALU op, 3-bit flags)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command request, sampled only in IDLE
- cmd  in  3  000 ADD, 001 ADC, 010 SUB, 011 INC, 100 AND, 101 OR, 110 XOR, 111 SHL
- a  in  16  operand A (ALU X side)
- b  in  16  operand B (ALU T side); ignored for INC/SHL
- cin  in  1  carry-in for ADC
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse, res/flags valid
- res  out  16  result, held until next accepted start
- flags  out  3  {S,Z,Cy}, held like res
- alu_x  out  8  to ALU x
- alu_y  out  8  to ALU y
- alu_cy  out  1  to ALU cy
- alu_op  out  5  to ALU op
- alu_flag  in  3  from ALU {S,Z,Cy}
- alu_result  in  8  from ALU result

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, res, flags, alu_x, alu_y, alu_cy and alu_op are all 0.
- FSM states and transitions:
  - IDLE -> LO on start.
  - LO -> HI unconditionally.
  - HI -> FIN unconditionally.
  - FIN -> IDLE unconditionally.
- Command capture: on start in IDLE, latch cmd, a, b and cin.
- ALU outputs are registered.
  - In LO they present low bytes.
  - In HI they present high bytes.
  - In IDLE and FIN they are all zero (op 00000).
- Capture points:
  - End of LO: latch alu_result into res_lo; latch alu_flag Cy and Z.
  - End of HI: latch alu_result into res_hi and alu_flag.
- Latency:
  - start sampled at edge N.
  - LO is active during cycle N+1; HI during N+2.
  - done=1 in cycle N+3; busy=0 in that same cycle.
  - busy=1 in cycles N+1..N+2.
- Per-command ALU programming (LO op / HI op, HI alu_cy):
  - ADD: 01000 / 01010, alu_cy = cy_lo. LO alu_cy = 0.
  - ADC: 01010 with alu_cy = cin / 01010, alu_cy = cy_lo.
  - SUB: 01011 / 01101, alu_cy = ~cy_lo.
    - ALU subtract-with-carry treats Cy=1 as borrow, while the LO carry-out is 1 for no-borrow; hence the inversion.
  - INC: 01110 / 01010 with alu_y = 0, alu_cy = cy_lo.
  - AND / OR / XOR: 10000 / 10001 / 10010 on both bytes. alu_cy = 0.
  - SHL: 11011 / 11010, alu_cy = cy_lo. LO bit 7 moves into HI bit 0.
- Flag merge:
  - S = HI S.
  - Z = Z_lo AND Z_hi.
  - Cy = HI carry-out raw; for SUB, 1 means no borrow.
  - Logic ops give Cy = 0.
- Handshake and boundaries:
  - start while busy or in FIN is ignored; no queuing.
  - start held high continuously re-triggers only once back in IDLE (back-to-back ops every 4 cycles).
  - Operand changes after acceptance do not affect the running op.
  - res/flags update only in the FIN cycle and are held otherwise.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse, and the prior res/flags are lost.
- 16-bit wrap-around is modular; the overflow indication is Cy only (no V flag).

Test Plan:
- ADD a=0x00FF b=0x0001 -> LO alu_op 01000, HI alu_op 01010 with alu_cy=1; res=0x0100, flags S0 Z0 Cy0; done exactly 3 cycles after start.
- ADD a=0xFFFF b=0x0001 -> res=0x0000, flags S0 Z1 Cy1. Then ADC a=b=0x0000 cin=1 -> res=0x0001, Z0.
- SUB a=0x1000 b=0x0001 -> HI alu_cy=1; res=0x0FFF, S0 Z0 Cy1. SUB a=0x0000 b=0x0001 -> res=0xFFFF, S1 Z0 Cy0.
- SHL a=0x8081 -> res=0x0102, Cy1. INC a=0x00FF -> 0x0100. XOR a=b=0x5A5A -> 0x0000, Z1 Cy0.
- start pulsed during busy with a different cmd/operands -> ignored; original result delivered; no second done.
- rst_n low during HI -> all outputs 0 asynchronously, no done. A subsequent ADD completes normally.
